// File: rtl/clk_enable_gen.sv
// clk_enable_gen: multi-channel programmable clock-enable generator.
// Each channel divides clock_5 by its own divider and emits single-cycle
// enable pulses. Periodic and one-shot modes are supported. Divider reloads
// are glitch-free, and sync_clr phase-aligns all running channels.
// Optional feature: define CLK_ENABLE_GEN_CASCADE_EN to chain the channels.
// In that build, channel n>0 counts only on the enable pulses of channel n-1.
module clk_enable_gen #(
    parameter int CHANNELS    = 4,
    parameter int CNT_WIDTH   = 21,
    parameter int DEFAULT_DIV = 10000
) (
    input  logic                 clock_5,
    input  logic                 reset,
    input  logic [CHANNELS-1:0]  ch_en,
    input  logic [CHANNELS-1:0]  oneshot,
    input  logic                 div_wr,
    input  logic [2:0]           div_sel,
    input  logic [CNT_WIDTH-1:0] div_data,
    input  logic                 sync_clr,
    output logic [CHANNELS-1:0]  enable_out,
    output logic [CHANNELS-1:0]  running
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] DIV_RST = CNT_WIDTH'(DEFAULT_DIV);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        state_t               state;
        logic [CNT_WIDTH-1:0] div;
        logic [CNT_WIDTH-1:0] pend;
        logic [CNT_WIDTH-1:0] cnt;
        logic [CNT_WIDTH-1:0] pend_next;
        logic                 sel;
        logic                 advance;
        logic                 last;
        logic                 pulse;
        logic                 run;

        // A write addressed to this channel. Out-of-range div_sel values never match.
        assign sel       = div_wr && (div_sel == 3'(i));
        assign pend_next = sel ? div_data : pend;
        // Use >= so that the counter can never go past DIV-1.
        assign last      = (cnt >= (div - CNT_ONE));

`ifdef CLK_ENABLE_GEN_CASCADE_EN
        if (i == 0) begin : g_head
            assign advance = 1'b1;
        end else begin : g_link
            assign advance = enable_out[i-1];
        end
`else
        assign advance = 1'b1;
`endif

        assign enable_out[i] = pulse;
        assign running[i]    = run;

        // Per-channel FSM: counter, divider reload, and registered pulse/running outputs.
        always_ff @(posedge clock_5 or negedge reset) begin
            if (!reset) begin
                state <= IDLE;
                cnt   <= '0;
                div   <= DIV_RST;
                pend  <= DIV_RST;
                pulse <= 1'b0;
                run   <= 1'b0;
            end else begin
                pend  <= pend_next;
                pulse <= 1'b0;
                case (state)
                    IDLE: begin
                        cnt <= '0;
                        div <= pend_next;
                        if (ch_en[i] && (pend_next != '0)) begin
                            state <= RUN;
                            run   <= 1'b1;
                        end
                    end
                    RUN: begin
                        if (!ch_en[i]) begin
                            state <= IDLE;
                            run   <= 1'b0;
                            cnt   <= '0;
                        end else if (sync_clr) begin
                            // Phase restart: no pulse, but a pending divider still lands.
                            cnt <= '0;
                            div <= pend_next;
                            if (pend_next == '0) begin
                                state <= IDLE;
                                run   <= 1'b0;
                            end
                        end else if (advance) begin
                            if (last) begin
                                cnt   <= '0;
                                pulse <= 1'b1;
                                div   <= pend_next;
                                if (oneshot[i]) begin
                                    state <= DONE;
                                    run   <= 1'b0;
                                end else if (pend_next == '0) begin
                                    state <= IDLE;
                                    run   <= 1'b0;
                                end
                            end else begin
                                cnt <= cnt + CNT_ONE;
                            end
                        end
                    end
                    DONE: begin
                        cnt <= '0;
                        div <= pend_next;
                        if (!ch_en[i]) begin
                            state <= IDLE;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        run   <= 1'b0;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_clk_enable_gen.sv
// tb_clk_enable_gen: directed bench for clk_enable_gen with hand-computed pulse timelines.
// Build with CLK_ENABLE_GEN_CASCADE_EN defined to exercise the divider chain.
module tb_clk_enable_gen;

    logic        clock_5 = 1'b0;
    logic        reset;
    logic [3:0]  ch_en;
    logic [3:0]  oneshot;
    logic        div_wr;
    logic [2:0]  div_sel;
    logic [20:0] div_data;
    logic        sync_clr;
    logic [3:0]  enable_out;
    logic [3:0]  running;

    int n_cmp = 0;
    int n_err = 0;

    clk_enable_gen #(
        .CHANNELS   (4),
        .CNT_WIDTH  (21),
        .DEFAULT_DIV(7)
    ) dut (
        .clock_5   (clock_5),
        .reset     (reset),
        .ch_en     (ch_en),
        .oneshot   (oneshot),
        .div_wr    (div_wr),
        .div_sel   (div_sel),
        .div_data  (div_data),
        .sync_clr  (sync_clr),
        .enable_out(enable_out),
        .running   (running)
    );

    always #5 clock_5 = ~clock_5;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock_5);
        #1;
    endtask

    task automatic wr_div(input logic [2:0] sel, input logic [20:0] data);
        div_wr   = 1'b1;
        div_sel  = sel;
        div_data = data;
        step();
        div_wr   = 1'b0;
    endtask

    initial begin
        reset    = 1'b0;
        ch_en    = '0;
        oneshot  = '0;
        div_wr   = 1'b0;
        div_sel  = '0;
        div_data = '0;
        sync_clr = 1'b0;
`ifndef CLK_ENABLE_GEN_CASCADE_EN
        ch_en = 4'b1000;
`endif
        #2;
        check("rst_enable", enable_out, 4'h0);
        check("rst_running", running, 4'h0);
        @(posedge clock_5);
        #1;
        reset = 1'b1;

`ifndef CLK_ENABLE_GEN_CASCADE_EN
        // ch_en held through reset: RUN on the first edge, default divider 7
        step();
        check("dflt_run", running[3], 1'b1);
        for (int k = 1; k <= 8; k++) begin
            step();
            check("dflt_pulse", enable_out[3], k == 7);
        end
        ch_en[3] = 1'b0;
        step();
        check("dflt_stop", running[3], 1'b0);
`endif

        // periodic DIV=4: pulses at 4, 8, 12; drop ch_en on the cycle before a due pulse
        wr_div(3'd0, 21'd4);
        step();
        ch_en[0] = 1'b1;
        step();
        check("per_run", running[0], 1'b1);
        check("per_c0", enable_out[0], 1'b0);
        for (int k = 1; k <= 15; k++) begin
            step();
            check("per_pulse", enable_out[0], (k % 4) == 0);
        end
        ch_en[0] = 1'b0;
        step();
        check("per_stop_run", running[0], 1'b0);
        check("per_stop_pulse", enable_out[0], 1'b0);
        step();
        check("per_idle_pulse", enable_out[0], 1'b0);

        // live reload: DIV=10, write 3 at CNT=2 -> pulses 10, 20, 23, 26
        wr_div(3'd0, 21'd10);
        ch_en[0] = 1'b1;
        step();
        for (int k = 1; k <= 27; k++) begin
            step();
            div_wr = 1'b0;
            check("reload_pulse", enable_out[0], (k == 10) || (k == 20) || (k == 23) || (k == 26));
            if (k == 12) begin
                div_wr   = 1'b1;
                div_sel  = 3'd0;
                div_data = 21'd3;
            end
        end
        div_wr   = 1'b0;
        ch_en[0] = 1'b0;
        step();

`ifndef CLK_ENABLE_GEN_CASCADE_EN
        // one-shot ch1 DIV=5: single pulse at 5, then parked until ch_en toggles
        wr_div(3'd1, 21'd5);
        oneshot[1] = 1'b1;
        ch_en[1]   = 1'b1;
        step();
        check("os_run", running[1], 1'b1);
        for (int k = 1; k <= 12; k++) begin
            step();
            check("os_pulse", enable_out[1], k == 5);
            check("os_running", running[1], k < 5);
        end
        ch_en[1] = 1'b0;
        step();
        ch_en[1] = 1'b1;
        step();
        check("os_rearm", running[1], 1'b1);
        ch_en[1]   = 1'b0;
        oneshot[1] = 1'b0;
        step();

        // DIV=1: high from the second RUN cycle on
        wr_div(3'd2, 21'd1);
        ch_en[2] = 1'b1;
        step();
        check("div1_c0", enable_out[2], 1'b0);
        check("div1_run", running[2], 1'b1);
        for (int k = 1; k <= 5; k++) begin
            step();
            check("div1_pulse", enable_out[2], 1'b1);
        end
        ch_en[2] = 1'b0;
        step();
        check("div1_stop", enable_out[2], 1'b0);
        check("div1_stop_run", running[2], 1'b0);

        // DIV=0: never runs
        wr_div(3'd2, 21'd0);
        ch_en[2] = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            step();
            check("div0_run", running[2], 1'b0);
            check("div0_pulse", enable_out[2], 1'b0);
        end
        ch_en[2] = 1'b0;

        // phase align: ch0 DIV=6, ch1 DIV=3 started 3 cycles later; sync when both are due
        wr_div(3'd0, 21'd6);
        wr_div(3'd1, 21'd3);
        ch_en[0] = 1'b1;
        step();
        step();
        step();
        ch_en[1] = 1'b1;
        step();
        step();
        step();
        sync_clr = 1'b1;
        step();
        sync_clr = 1'b0;
        check("sync_quiet", enable_out[1:0], 2'b00);
        for (int j = 1; j <= 7; j++) begin
            step();
            check("sync_align", enable_out[1:0], {(j == 3) || (j == 6), j == 6});
        end
        ch_en = '0;
        step();
`endif

`ifdef CLK_ENABLE_GEN_CASCADE_EN
        // chain: ch0 DIV=5 feeds ch1 DIV=2 -> ch1 pulses at 11, 21
        wr_div(3'd0, 21'd5);
        wr_div(3'd1, 21'd2);
        ch_en[1:0] = 2'b11;
        step();
        for (int k = 1; k <= 22; k++) begin
            step();
            check("casc_ch1", enable_out[1], (k == 11) || (k == 21));
        end
        ch_en = '0;
        step();
`endif

        // async reset while a pulse is high: outputs clear without waiting for a clock edge
        wr_div(3'd0, 21'd6);
        ch_en[0] = 1'b1;
        step();
        for (int k = 1; k <= 6; k++) begin
            step();
        end
        check("pre_rst_pulse", enable_out[0], 1'b1);
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_enable", enable_out, 4'h0);
        check("async_rst_running", running, 4'h0);
        ch_en = '0;
        @(posedge clock_5);
        #1;
        reset = 1'b1;

        // out-of-range div_sel must not touch ch0, which keeps its reset divider of 7
        wr_div(3'd4, 21'd2);
        ch_en[0] = 1'b1;
        step();
        check("post_rst_run", running[0], 1'b1);
        for (int k = 1; k <= 8; k++) begin
            step();
            check("post_rst_pulse", enable_out[0], k == 7);
        end
        ch_en = '0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/clk_enable_gen.md
CLK_ENABLE_GEN -- requirements
Module: clk_enable_gen

Interface
REQ-001 Parameter CHANNELS, default 4, number of independent enable channels (1..8).
REQ-002 Parameter CNT_WIDTH, default 21, width of every divider and counter.
REQ-003 Parameter DEFAULT_DIV, default 10000, divider value loaded into every channel at reset.
REQ-004 Port clock_5  input  1  system clock; all logic is on its rising edge.
REQ-005 Port reset  input  1  asynchronous, active-low reset.
REQ-006 Port ch_en  input  CHANNELS  per-channel run request; level-sensitive.
REQ-007 Port oneshot  input  CHANNELS  per-channel mode: 0 = periodic, 1 = one-shot.
REQ-008 Port div_wr  input  1  single-cycle write strobe for a divider value.
REQ-009 Port div_sel  input  3  channel index addressed by div_wr.
REQ-010 Port div_data  input  CNT_WIDTH  divider value written by div_wr.
REQ-011 Port sync_clr  input  1  synchronous phase-align of all channels.
REQ-012 Port enable_out  output  CHANNELS  registered one-cycle enable pulses.
REQ-013 Port running  output  CHANNELS  channel is counting.

Function
REQ-014 Each channel SHALL hold an active divider DIV and a pending divider PEND, a counter CNT, and a state IDLE, RUN or DONE.
- IDLE -> RUN: ch_en=1 and DIV!=0; CNT is 0 in the first RUN cycle.
- RUN -> IDLE: ch_en=0; CNT is cleared, and no pulse is emitted in that cycle or later.
- RUN -> DONE: a one-shot pulse is emitted.
- DONE -> IDLE: ch_en=0.
REQ-015 In RUN, CNT SHALL increment by 1 per cycle and wrap from DIV-1 to 0; enable_out[i] SHALL be 1 in the cycle after CNT==DIV-1, giving exactly one pulse every DIV cycles.
REQ-016 The first pulse SHALL appear DIV cycles after the first RUN cycle.
REQ-017 DIV==1 SHALL give enable_out[i] high in every RUN cycle after the first.
REQ-018 DIV==0 SHALL keep the channel in IDLE, with no pulses.
REQ-019 In one-shot mode the channel SHALL emit exactly one pulse, enter DONE, and stay there with running=0 until ch_en drops; ch_en must fall and rise again for a new shot.
REQ-020 running[i] SHALL be 1 exactly when the channel is in RUN.
REQ-021 div_wr SHALL store div_data into PEND of channel div_sel; div_sel >= CHANNELS SHALL be ignored.
REQ-022 PEND SHALL be copied to DIV immediately when the channel is IDLE or DONE.
REQ-023 PEND SHALL be copied to DIV at the next wrap when the channel is in RUN, so the current period is never shortened or stretched.
REQ-024 A div_wr in the same cycle as a wrap SHALL apply from the period that begins with that wrap.
REQ-025 sync_clr SHALL set CNT to 0 in all RUN channels and suppress any pulse due in the following cycle; sync_clr takes priority over wrap and tick; PEND SHALL still transfer.
REQ-026 No counter SHALL exceed DIV-1.
REQ-027 Counter arithmetic SHALL be unsigned CNT_WIDTH bits; values that do not fit are truncated at write.

Reset
REQ-028 On reset=0, independent of the clock:
- all channels go to IDLE;
- CNT=0;
- DIV=PEND=DEFAULT_DIV;
- enable_out=0 and running=0.
REQ-029 Reset asserted mid-period SHALL abort the period with no partial pulse.
REQ-030 After reset release, a channel with ch_en=1 SHALL enter RUN on the first clock edge.

Configuration
REQ-031 With macro CLK_ENABLE_GEN_CASCADE_EN defined, channel n>0 SHALL advance CNT only in cycles where enable_out[n-1] is 1, giving a divider chain; channel 0 is unchanged.
REQ-032 Without CLK_ENABLE_GEN_CASCADE_EN, every channel SHALL advance on every clock_5 cycle.

Verification
REQ-033 Periodic: reset, ch0 DIV=4, ch_en[0]=1 -> pulses at cycles 4, 8, 12 after RUN entry, each 1 cycle wide.
REQ-034 Live reload: DIV=10 running, write 3 at CNT=2 -> next pulse still 10 cycles after the previous one, then every 3 cycles.
REQ-035 One-shot: oneshot[1]=1, DIV=5, ch_en[1] held high -> single pulse at cycle 5, running[1]=0 afterwards, no further pulses.
REQ-036 Edge dividers: DIV=1 -> enable_out continuously high from the 2nd RUN cycle; DIV=0 -> running=0, no pulses.
REQ-037 Phase align: ch0 DIV=6 and ch1 DIV=3 with offset start, assert sync_clr -> both pulse together 6 cycles later, with no pulse in the cycle after sync_clr.
REQ-038 Cascade (macro defined): ch0 DIV=5, ch1 DIV=2 -> ch1 pulses every 10 cycles; async reset mid-run -> all outputs 0 immediately.
